// File: rtl/trap_pkg.sv
// trap_pkg: cause codes, CSR addresses, mstatus bit positions and FSM states for trap_ctrl
package trap_pkg;
  localparam logic [4:0] TRAP_INS_MISALIGN = 5'd0;
  localparam logic [4:0] TRAP_ILLEGAL = 5'd2;
  localparam logic [4:0] TRAP_EBREAK = 5'd3;
  localparam logic [4:0] TRAP_LOAD_MISALIGN = 5'd4;
  localparam logic [4:0] TRAP_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] TRAP_ECALL = 5'd11;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam int MIE_BIT = 3;
  localparam int MPIE_BIT = 7;
  typedef enum logic [1:0] {IDLE, TRAP_JUMP, MRET_JUMP} state_t;
endpackage

// File: rtl/trap_encode.sv
// trap_encode: fixed-priority encoder from exception flags to mcause code
module trap_encode
  import trap_pkg::*;
(
  input  logic       ins_illegal,
  input  logic       ins_misalign,
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       store_misalign,
  input  logic       load_misalign,
  output logic       valid,
  output logic [4:0] code
);
  assign valid = ins_illegal | ins_misalign | ecall | ebreak | store_misalign | load_misalign;
  assign code = ins_illegal ? TRAP_ILLEGAL :
                ins_misalign ? TRAP_INS_MISALIGN :
                ecall ? TRAP_ECALL :
                ebreak ? TRAP_EBREAK :
                store_misalign ? TRAP_STORE_MISALIGN : TRAP_LOAD_MISALIGN;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer owning mtvec/mepc/mcause/mtval/mstatus
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_valid,
  input  logic [31:0] pc,
  input  logic [31:0] tval,
  input  logic        ins_illegal,
  input  logic        ins_misalign,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        store_misalign,
  input  logic        load_misalign,
  input  logic        mret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  state_t state, state_nx;
  logic [31:0] mtvec, mepc, mcause, mtval;
  logic mie, mpie, exc, trap, ret, jump, csr_wr, keep_tval;
  logic [4:0] code;
  trap_encode u_encode (
    .ins_illegal(ins_illegal),
    .ins_misalign(ins_misalign),
    .ecall(ecall),
    .ebreak(ebreak),
    .store_misalign(store_misalign),
    .load_misalign(load_misalign),
    .valid(exc),
    .code(code)
  );
  always_comb begin
    trap = (state == IDLE) & retire_valid & exc;
    ret = (state == IDLE) & retire_valid & mret & ~exc;
    jump = state != IDLE;
    state_nx = trap ? TRAP_JUMP : ret ? MRET_JUMP : IDLE;
    stall = trap | ret | jump;
    flush = jump;
    redirect_valid = jump;
    redirect_pc = state == TRAP_JUMP ? {mtvec[31:2], 2'b00} : state == MRET_JUMP ? mepc : 32'h0;
    csr_wr = csr_we & ~trap;
    keep_tval = code == TRAP_INS_MISALIGN || code == TRAP_LOAD_MISALIGN || code == TRAP_STORE_MISALIGN;
  end
  always_comb begin
    csr_rdata = 32'h0;
    csr_rdata = csr_addr == CSR_MSTATUS ? {24'h0, mpie, 3'b000, mie, 3'b000} :
                csr_addr == CSR_MTVEC ? mtvec :
                csr_addr == CSR_MEPC ? mepc :
                csr_addr == CSR_MCAUSE ? mcause :
                csr_addr == CSR_MTVAL ? mtval : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mtvec <= {MTVEC_RESET[31:2], 2'b00};
      mepc <= 32'h0;
      mcause <= 32'h0;
      mtval <= 32'h0;
      mie <= 1'b0;
      mpie <= 1'b0;
    end else begin
      state <= state_nx;
      if (trap) begin
        mepc <= {pc[31:2], 2'b00};
        mcause <= {27'h0, code};
        mtval <= keep_tval ? tval : 32'h0;
        mpie <= mie;
        mie <= 1'b0;
      end else begin
        if (csr_wr && csr_addr == CSR_MTVEC) mtvec <= {csr_wdata[31:2], 2'b00};
        if (csr_wr && csr_addr == CSR_MEPC) mepc <= {csr_wdata[31:2], 2'b00};
        if (csr_wr && csr_addr == CSR_MCAUSE) mcause <= csr_wdata;
        if (csr_wr && csr_addr == CSR_MTVAL) mtval <= csr_wdata;
        // mret's MIE/MPIE restore owns mstatus in MRET_JUMP, so software writes there lose
        if (state == MRET_JUMP) begin
          mie <= mpie;
          mpie <= 1'b1;
        end else if (csr_wr && csr_addr == CSR_MSTATUS) begin
          mie <= csr_wdata[MIE_BIT];
          mpie <= csr_wdata[MPIE_BIT];
        end
      end
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed-vector bench for trap_ctrl
module tb_trap_ctrl;
  logic clk = 0, rst = 1, retire_valid = 0, mret = 0, csr_we = 0;
  logic ins_illegal = 0, ins_misalign = 0, ecall = 0, ebreak = 0, store_misalign = 0, load_misalign = 0;
  logic [31:0] pc = 0, tval = 0, csr_wdata = 0, csr_rdata, redirect_pc;
  logic [11:0] csr_addr = 0;
  logic stall, flush, redirect_valid;
  int n_cmp = 0, n_bad = 0;
  always #10 clk = ~clk;
  trap_ctrl dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .pc(pc), .tval(tval),
    .ins_illegal(ins_illegal), .ins_misalign(ins_misalign), .ecall(ecall), .ebreak(ebreak),
    .store_misalign(store_misalign), .load_misalign(load_misalign), .mret(mret),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask
  task automatic clr();
    {retire_valid, mret, csr_we, ins_illegal, ins_misalign, ecall, ebreak, store_misalign, load_misalign} = '0;
  endtask
  task automatic outs(input string tag, input logic [2:0] exp_svf, input logic [31:0] exp_pc);
    #1;
    chk({tag, "_svf"}, {29'h0, stall, redirect_valid, flush}, {29'h0, exp_svf});
    chk({tag, "_rpc"}, redirect_pc, exp_pc);
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    outs("rst", 3'b000, 0);
    rd("rst_mtvec", 12'h305, 32'h100);
    rd("rst_mepc", 12'h341, 0);
    rd("rst_mcause", 12'h342, 0);
    rd("rst_mtval", 12'h343, 0);
    rd("rst_mstatus", 12'h300, 0);
    // ecall
    pc = 32'h1004; ecall = 1; retire_valid = 1;
    outs("ecall_n", 3'b100, 0);
    tick(); clr();
    outs("ecall_n1", 3'b111, 32'h100);
    rd("ecall_mepc_n1", 12'h341, 32'h1004);
    tick();
    outs("ecall_n2", 3'b000, 0);
    rd("ecall_mcause", 12'h342, 11);
    rd("ecall_mtval", 12'h343, 0);
    rd("ecall_mstatus", 12'h300, 0);
    // MIE=1, load misalign, then mret
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'hFFFF_FF08;
    tick(); clr();
    rd("mie_set", 12'h300, 32'h8);
    pc = 32'h2000; tval = 32'h2003; load_misalign = 1; retire_valid = 1;
    tick(); clr(); tick();
    rd("ld_mtval", 12'h343, 32'h2003);
    rd("ld_mcause", 12'h342, 4);
    rd("ld_mstatus", 12'h300, 32'h80);
    mret = 1; retire_valid = 1;
    outs("mret_n", 3'b100, 0);
    tick(); clr();
    outs("mret_n1", 3'b111, 32'h2000);
    tick();
    outs("mret_n2", 3'b000, 0);
    rd("mret_mstatus", 12'h300, 32'h88);
    // priority plus dropped CSR write
    pc = 32'h3008; tval = 32'h55; ins_illegal = 1; ebreak = 1; load_misalign = 1; retire_valid = 1;
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h4000;
    tick(); clr();
    outs("prio_n1", 3'b111, 32'h100);
    tick();
    rd("prio_mcause", 12'h342, 2);
    rd("prio_mtval", 12'h343, 0);
    rd("prio_mtvec", 12'h305, 32'h100);
    rd("prio_mepc", 12'h341, 32'h3008);
    rd("prio_mstatus", 12'h300, 32'h80);
    // flags without retire_valid
    ecall = 1;
    outs("noret", 3'b000, 0);
    tick(); clr();
    outs("noret_n1", 3'b000, 0);
    rd("noret_mcause", 12'h342, 2);
    // mtvec masking and redirect; pc low bits cleared in mepc
    csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h2003;
    tick(); clr();
    rd("mtvec_mask", 12'h305, 32'h2000);
    pc = 32'h4002; tval = 32'h5555; ins_misalign = 1; store_misalign = 1; retire_valid = 1;
    tick(); clr();
    outs("vec_n1", 3'b111, 32'h2000);
    tick();
    rd("im_mcause", 12'h342, 0);
    rd("im_mtval", 12'h343, 32'h5555);
    rd("im_mepc", 12'h341, 32'h4000);
    // trap beats mret; CSR writes still land in TRAP_JUMP
    pc = 32'h5000; ecall = 1; mret = 1; retire_valid = 1;
    tick(); clr();
    outs("tvm_n1", 3'b111, 32'h2000);
    csr_we = 1; csr_addr = 12'h342; csr_wdata = 32'hDEAD_BEEF;
    tick(); clr();
    rd("tj_mcause_wr", 12'h342, 32'hDEAD_BEEF);
    csr_we = 1; csr_addr = 12'h344; csr_wdata = 32'h1234;
    tick(); clr();
    rd("unmapped", 12'h344, 0);
    // mstatus write in MRET_JUMP is dropped
    mret = 1; retire_valid = 1;
    tick(); clr();
    outs("mj_n1", 3'b111, 32'h5000);
    csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h8;
    tick(); clr();
    rd("mj_mstatus", 12'h300, 32'h80);
    // reset in TRAP_JUMP
    pc = 32'h6000; ecall = 1; retire_valid = 1;
    tick(); clr();
    outs("rtj_n1", 3'b111, 32'h2000);
    rst = 1;
    tick();
    rst = 0;
    outs("rtj_after", 3'b000, 0);
    rd("rtj_mtvec", 12'h305, 32'h100);
    rd("rtj_mepc", 12'h341, 0);
    rd("rtj_mcause", 12'h342, 0);
    rd("rtj_mstatus", 12'h300, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
